// File: rtl/tw_pkg.sv
// Shared definitions for the tw_core fetch/execute processor.
// TW_HALT_EN adds the HALT state (opcode 1000 stops the core).
package tw_pkg;

  localparam int OP_W    = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADDA  = 4'b0000,
    OP_MOVAB = 4'b0001,
    OP_INA   = 4'b0010,
    OP_LDA   = 4'b0011,
    OP_MOVBA = 4'b0100,
    OP_ADDB  = 4'b0101,
    OP_INB   = 4'b0110,
    OP_LDB   = 4'b0111,
    OP_HLT   = 4'b1000,
    OP_OUTB  = 4'b1001,
    OP_NOP_A = 4'b1010,
    OP_OUTI  = 4'b1011,
    OP_NOP_C = 4'b1100,
    OP_NOP_D = 4'b1101,
    OP_JNC   = 4'b1110,
    OP_JMP   = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1
`ifdef TW_HALT_EN
    ,
    ST_HALT  = 2'd2
`endif
  } state_t;

  // The opcode sits directly above the immediate field.
  function automatic int op_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/tw_alu.sv
// DATA_W-bit adder with carry-out, shared by both add opcodes.
module tw_alu
  import tw_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/tw_core.sv
// Two-state fetch/execute core with an external program ROM behind a req/ack handshake.
// Define TW_HALT_EN to make opcode 1000 halt the core until reset.
module tw_core
  import tw_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   fetch_req,
  output logic [ADDR_W-1:0]      fetch_addr,
  input  logic                   fetch_ack,
  input  logic [OP_W+DATA_W-1:0] fetch_data,
  input  logic [DATA_W-1:0]      in,
  output logic [DATA_W-1:0]      out,
  output logic                   halted
);

  localparam int OP_LSB = op_lsb(DATA_W);

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        pc;
  logic [DATA_W-1:0]        a, b;
  logic                     carry;
  logic [OP_W+DATA_W-1:0]   ir;

  opcode_t                  op;
  logic [DATA_W-1:0]        imm;
  logic [ADDR_W-1:0]        imm_addr;
  logic [DATA_W-1:0]        alu_a, alu_sum;
  logic                     alu_carry;

  assign op  = opcode_t'(ir[OP_LSB +: OP_W]);
  assign imm = ir[IMM_LSB +: DATA_W];

  if (ADDR_W <= DATA_W) begin : g_imm_trunc
    assign imm_addr = imm[ADDR_W-1:0];
  end else begin : g_imm_ext
    assign imm_addr = {{(ADDR_W-DATA_W){1'b0}}, imm};
  end

  assign alu_a = (op == OP_ADDB) ? b : a;

  tw_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (alu_a),
    .b     (imm),
    .sum   (alu_sum),
    .carry (alu_carry)
  );

  assign fetch_req  = (state == ST_FETCH);
  assign fetch_addr = pc;

`ifdef TW_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  // NOTE: assign a default before the case so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: if (fetch_ack) state_next = ST_EXEC;
      ST_EXEC: begin
        state_next = ST_FETCH;
`ifdef TW_HALT_EN
        if (op == OP_HLT) state_next = ST_HALT;
`endif
      end
`ifdef TW_HALT_EN
      ST_HALT: state_next = ST_HALT;
`endif
      default: state_next = ST_FETCH;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      a     <= '0;
      b     <= '0;
      carry <= 1'b0;
      ir    <= '0;
      out   <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_FETCH: if (fetch_ack) ir <= fetch_data;
        ST_EXEC: begin
`ifdef TW_HALT_EN
          if (op != OP_HLT) begin
`else
          begin
`endif
            // Non-add instructions clear carry; jumps test the value before this clear.
            carry <= 1'b0;
            pc    <= pc + ADDR_W'(1);
            case (op)
              OP_ADDA:  begin a <= alu_sum; carry <= alu_carry; end
              OP_MOVAB: a <= b;
              OP_INA:   a <= in;
              OP_LDA:   a <= imm;
              OP_MOVBA: b <= a;
              OP_ADDB:  begin b <= alu_sum; carry <= alu_carry; end
              OP_INB:   b <= in;
              OP_LDB:   b <= imm;
              OP_OUTB:  out <= b;
              OP_OUTI:  out <= imm;
              OP_JNC:   if (!carry) pc <= imm_addr;
              OP_JMP:   pc <= imm_addr;
              default:  ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_core.sv
// Self-checking bench for tw_core: a 4-bit and an 8-bit/6-bit instance against an ISA-level model.
// Halt behaviour is exercised when TW_HALT_EN is defined.
module tb_tw_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  bit         sel   = 1'b0;
  logic       ack   = 1'b0;
  logic [3:0] op_v  = 4'h0;
  logic [7:0] imm_v = 8'h00;
  logic [7:0] in_v  = 8'h00;

  logic        req4, halt4, req8, halt8;
  logic [3:0]  addr4, out4;
  logic [5:0]  addr8;
  logic [7:0]  out8;
  logic [7:0]  fd4;
  logic [11:0] fd8;
  logic        ack4, ack8;

  logic       req_o, halt_o;
  logic [7:0] addr_o, out_o;

  assign fd4  = {op_v, imm_v[3:0]};
  assign fd8  = {op_v, imm_v};
  assign ack4 = ack & !sel;
  assign ack8 = ack & sel;

  assign req_o  = sel ? req8 : req4;
  assign halt_o = sel ? halt8 : halt4;
  assign addr_o = sel ? {2'b00, addr8} : {4'h0, addr4};
  assign out_o  = sel ? out8 : {4'h0, out4};

  tw_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clock(clock), .reset(reset), .fetch_req(req4), .fetch_addr(addr4),
    .fetch_ack(ack4), .fetch_data(fd4), .in(in_v[3:0]), .out(out4), .halted(halt4)
  );

  tw_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clock(clock), .reset(reset), .fetch_req(req8), .fetch_addr(addr8),
    .fetch_ack(ack8), .fetch_data(fd8), .in(in_v), .out(out8), .halted(halt8)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [3:0] prog_op  [64];
  logic [7:0] prog_imm [64];

  // Architectural model: registers as plain integers, widths taken from the selected instance.
  int m_pc, m_a, m_b, m_c, m_out;

  function automatic int dw();
    return sel ? 8 : 4;
  endfunction

  function automatic int aw();
    return sel ? 6 : 4;
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
  endfunction

  function automatic void model_exec(input int op, input int imm_raw, input int inv);
    int mask_d   = (1 << dw()) - 1;
    int mask_a   = (1 << aw()) - 1;
    int imm      = imm_raw & mask_d;
    int carry_in = m_c;
    int nxt      = (m_pc + 1) & mask_a;
    int s;
    m_c = 0;
    case (op)
      0:  begin s = m_a + imm; m_a = s & mask_d; m_c = s >> dw(); end
      1:  m_a = m_b;
      2:  m_a = inv & mask_d;
      3:  m_a = imm;
      4:  m_b = m_a;
      5:  begin s = m_b + imm; m_b = s & mask_d; m_c = s >> dw(); end
      6:  m_b = inv & mask_d;
      7:  m_b = imm;
      9:  m_out = m_b;
      11: m_out = imm;
      14: if (carry_in == 0) nxt = imm_raw & mask_d & mask_a;
      15: nxt = imm & mask_a;
      default: ;
    endcase
    m_pc = nxt;
  endfunction

  function automatic void fill_nop();
    for (int i = 0; i < 64; i++) begin
      prog_op[i]  = 4'hA;
      prog_imm[i] = 8'h00;
    end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < 64; i++) begin
      prog_op[i]  = 4'($urandom_range(15));
`ifdef TW_HALT_EN
      if (prog_op[i] == 4'h8) prog_op[i] = 4'h9;
`endif
      prog_imm[i] = 8'($urandom);
    end
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    ack = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Serves one fetch with lat wait cycles, then lets the EXEC cycle retire.
  task automatic step_instr(input int lat, input int force_in, output int wait_n,
                            output logic [7:0] got_addr, output bit stable,
                            output logic exec_req, output logic [7:0] got_out,
                            output logic got_halt, output int exec_in);
    wait_n = 0;
    while (req_o !== 1'b1 && wait_n < 10) begin
      @(negedge clock);
      wait_n++;
    end
    if (req_o !== 1'b1) begin
      wait_n = -1; stable = 0; got_addr = 'x; exec_req = 'x;
      got_out = 'x; got_halt = 'x; exec_in = 0;
      return;
    end
    got_addr = addr_o;
    stable   = 1;
    for (int w = 0; w < lat; w++) begin
      in_v = 8'($urandom);
      @(negedge clock);
      if (req_o !== 1'b1 || addr_o !== got_addr) stable = 0;
    end
    ack   = 1'b1;
    op_v  = prog_op[got_addr[5:0]];
    imm_v = prog_imm[got_addr[5:0]];
    in_v  = 8'($urandom);
    @(negedge clock);
    ack   = 1'b0;
    op_v  = 4'($urandom);
    imm_v = 8'($urandom);
    in_v  = (force_in >= 0) ? 8'(force_in) : 8'($urandom);
    exec_in  = int'(in_v);
    exec_req = req_o;
    @(negedge clock);
    got_out  = out_o;
    got_halt = halt_o;
    in_v     = 8'($urandom);
  endtask

  task automatic run_and_check(input string tag, input int n, input int lat, input int force_in);
    for (int i = 0; i < n; i++) begin
      int         wait_n, exec_in, exp_pc;
      logic [7:0] got_addr, got_out;
      bit         stable;
      logic       exec_req, got_halt;
      exp_pc = m_pc;
      step_instr(lat, force_in, wait_n, got_addr, stable, exec_req, got_out, got_halt, exec_in);
      total++;
      if (wait_n != 0) $display("FAIL %s_req_ready: waited %0d cycles, required 0", tag, wait_n);
      else passed++;
      total++;
      if (got_addr !== 8'(exp_pc)) $display("FAIL %s_addr: got %0h required %0h", tag, got_addr, exp_pc);
      else passed++;
      total++;
      if (stable !== 1'b1) $display("FAIL %s_addr_stable: got %0d required 1", tag, stable);
      else passed++;
      total++;
      if (exec_req !== 1'b0) $display("FAIL %s_exec_req: got %b required 0", tag, exec_req);
      else passed++;
      model_exec(int'(prog_op[exp_pc]), int'(prog_imm[exp_pc]), exec_in);
      total++;
      if (got_out !== 8'(m_out)) $display("FAIL %s_out: got %0h required %0h", tag, got_out, m_out);
      else passed++;
      total++;
      if (got_halt !== 1'b0) $display("FAIL %s_halted: got %b required 0", tag, got_halt);
      else passed++;
      if (wait_n < 0) break;
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #1 reset = 1'b1;
    #2;
    total++;
    if (req_o !== 1'b1 || addr_o !== 8'h00)
      $display("FAIL reset_fetch: req %b addr %0h required 1/0", req_o, addr_o);
    else passed++;
    total++;
    if (out_o !== 8'h00 || halt_o !== 1'b0 || out8 !== 8'h00)
      $display("FAIL reset_out: out %0h halted %b required 0/0", out_o, halt_o);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (req_o !== 1'b1 || addr_o !== 8'h00 || req8 !== 1'b1 || addr8 !== 6'h00)
      $display("FAIL post_reset_fetch: req %b addr %0h required 1/0", req_o, addr_o);
    else passed++;
    model_reset();
  endtask

  task automatic load_add_carry();
    fill_nop();
    prog_op[0] = 4'h3; prog_imm[0] = 8'h03;
    prog_op[1] = 4'h0; prog_imm[1] = 8'h0E;
    prog_op[2] = 4'hE; prog_imm[2] = 8'h00;
    prog_op[3] = 4'h4; prog_imm[3] = 8'h00;
    prog_op[4] = 4'h9; prog_imm[4] = 8'h00;
  endtask

  task automatic test_add_carry();
    sel = 0;
    apply_reset();
    load_add_carry();
    run_and_check("add_carry", 5, 0, -1);
    total++;
    if (out_o !== 8'h01) $display("FAIL add_carry_result: got %0h required 1", out_o);
    else passed++;
  endtask

  task automatic test_out_jmp();
    sel = 0;
    apply_reset();
    fill_nop();
    prog_op[0] = 4'hB; prog_imm[0] = 8'h05;
    prog_op[1] = 4'hF; prog_imm[1] = 8'h00;
    run_and_check("out_jmp", 6, 0, -1);
    total++;
    if (out_o !== 8'h05) $display("FAIL out_jmp_hold: got %0h required 5", out_o);
    else passed++;
  endtask

  task automatic test_wait_states();
    sel = 0;
    apply_reset();
    load_add_carry();
    run_and_check("wait3", 5, 3, -1);
    total++;
    if (out_o !== 8'h01) $display("FAIL wait3_result: got %0h required 1", out_o);
    else passed++;
  endtask

  task automatic test_random();
    sel = 0;
    for (int p = 0; p < 4; p++) begin
      apply_reset();
      fill_random();
      run_and_check("rand4", 25, $urandom_range(2), -1);
    end
  endtask

  task automatic test_wide();
    sel = 1;
    apply_reset();
    fill_nop();
    prog_op[0]  = 4'h6; prog_imm[0]  = 8'h00;
    prog_op[1]  = 4'h9; prog_imm[1]  = 8'h00;
    prog_op[2]  = 4'hF; prog_imm[2]  = 8'hFF;
    prog_op[63] = 4'hB; prog_imm[63] = 8'h3C;
    run_and_check("wide_in", 2, 0, 8'hA5);
    total++;
    if (out_o !== 8'hA5) $display("FAIL wide_out: got %0h required a5", out_o);
    else passed++;
    run_and_check("wide_jmp", 3, 0, -1);
    apply_reset();
    fill_random();
    run_and_check("rand8", 25, $urandom_range(2), -1);
    sel = 0;
  endtask

  task automatic test_reset_pending();
    sel = 0;
    apply_reset();
    fill_nop();
    prog_op[0] = 4'h3; prog_imm[0] = 8'h07;
    prog_op[1] = 4'h7; prog_imm[1] = 8'h09;
    prog_op[2] = 4'hB; prog_imm[2] = 8'h06;
    run_and_check("pre_reset", 3, 0, -1);
    // Fetch of address 3 is pending; reset hits and the ack lands inside it.
    ack = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    ack = 1'b1; op_v = 4'hB; imm_v = 8'h0F;
    @(negedge clock);
    total++;
    if (out_o !== 8'h00) $display("FAIL in_reset_out: got %0h required 0", out_o);
    else passed++;
    reset = 1'b0;
    ack   = 1'b0;
    #1;
    total++;
    if (req_o !== 1'b1 || addr_o !== 8'h00)
      $display("FAIL refetch: req %b addr %0h required 1/0", req_o, addr_o);
    else passed++;
    model_reset();
    fill_nop();
    prog_op[0] = 4'h9;
    prog_op[1] = 4'h4;
    prog_op[2] = 4'h9;
    prog_op[3] = 4'hE; prog_imm[3] = 8'h00;
    run_and_check("post_reset", 4, 0, -1);
  endtask

  task automatic test_halt();
    sel = 0;
    apply_reset();
    fill_nop();
    prog_op[0] = 4'h8;
`ifdef TW_HALT_EN
    begin
      int         wait_n, exec_in;
      logic [7:0] got_addr, got_out;
      bit         stable;
      logic       exec_req, got_halt;
      step_instr(0, -1, wait_n, got_addr, stable, exec_req, got_out, got_halt, exec_in);
      total++;
      if (got_halt !== 1'b1) $display("FAIL halt_set: got %b required 1", got_halt);
      else passed++;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        total++;
        if (req_o !== 1'b0 || halt_o !== 1'b1)
          $display("FAIL halt_frozen: req %b halted %b required 0/1", req_o, halt_o);
        else passed++;
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (halt_o !== 1'b0 || req_o !== 1'b1)
        $display("FAIL halt_reset: halted %b req %b required 0/1", halt_o, req_o);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
    end
`else
    prog_op[1] = 4'hB; prog_imm[1] = 8'h09;
    run_and_check("hlt_nop", 3, 0, -1);
`endif
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_out_jmp();
    test_wait_states();
    test_random();
    test_wide();
    test_reset_pending();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
